// File: rtl/ee469_pkg.sv
// Shared writeback-stage types and constants for the ee469 pipeline.
// Imported by wb_stage and its interface.
package ee469_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_t;

    localparam logic [4:0] XZR_ADDR = 5'd31;

    // LDURB zero-extends the low byte; LDUR takes the full doubleword.
    function automatic logic [63:0] load_data(input logic is_byte, input logic [63:0] rdata);
        return is_byte ? {56'b0, rdata[7:0]} : rdata;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake, load-return and register-file write bundle for wb_stage.
interface wb_stage_if;
    logic        valid_in;
    logic        RegWrite_in;
    logic        load_in;
    logic        byte_in;
    logic        MOVsel_in;
    logic [4:0]  Aw_in;
    logic [63:0] ALUout_in;
    logic [63:0] MOVout_in;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;
    logic        flush;
    logic        RegWrite;
    logic [4:0]  AwWB;
    logic [63:0] Dw;
    logic        stall;
    logic        timeout_err;

    modport master (
        output valid_in, RegWrite_in, load_in, byte_in, MOVsel_in, Aw_in,
               ALUout_in, MOVout_in, mem_rdata, mem_rvalid, flush,
        input  RegWrite, AwWB, Dw, stall, timeout_err
    );

    modport slave (
        input  valid_in, RegWrite_in, load_in, byte_in, MOVsel_in, Aw_in,
               ALUout_in, MOVout_in, mem_rdata, mem_rvalid, flush,
        output RegWrite, AwWB, Dw, stall, timeout_err
    );
endinterface

// File: rtl/wb_timeout.sv
// Load-wait cycle counter and sticky timeout flag for wb_stage.
// Only instantiated when WB_TIMEOUT_EN is defined.
module wb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enter,
    input  logic waiting,
    input  logic cancel,
    output logic expire,
    output logic err
);

    // Expiry is flagged on the wait edge that brings the count to TIMEOUT_CYCLES.
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt;

    assign expire = waiting && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (enter)
                cnt <= '0;
            else if (waiting && cnt != '1)
                cnt <= cnt + 8'd1;
            if (expire && !cancel)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: buffers one instruction, waits for load data, drives the RF write port.
// Optional load-wait timeout enabled by defining WB_TIMEOUT_EN.
module wb_stage
    import ee469_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic       clk,
    input logic       reset_n,
    wb_stage_if.slave wb
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("wb_stage: TIMEOUT_CYCLES must be in 2..255");
    end

    wb_state_t   state;
    logic        ld_byte;
    logic        ld_rw;
    logic [4:0]  ld_aw;
    logic        wr_q;
    logic [4:0]  aw_q;
    logic [63:0] dw_q;
    logic        waiting;
    logic        expire;

    assign waiting     = (state == WAIT_MEM);
    assign wb.stall    = waiting;
    assign wb.RegWrite = wr_q;
    assign wb.AwWB     = aw_q;
    assign wb.Dw       = dw_q;

`ifdef WB_TIMEOUT_EN
    logic enter_wait;
    assign enter_wait = !waiting && wb.valid_in && wb.load_in && !wb.flush;

    wb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .enter   (enter_wait),
        .waiting (waiting),
        .cancel  (wb.flush || wb.mem_rvalid),
        .expire  (expire),
        .err     (wb.timeout_err)
    );
`else
    assign expire         = 1'b0;
    assign wb.timeout_err = 1'b0;
`endif

    // Write-port outputs are registered and default to zero; they are loaded only on entry to WRITE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ld_byte <= 1'b0;
            ld_rw   <= 1'b0;
            ld_aw   <= '0;
            wr_q    <= 1'b0;
            aw_q    <= '0;
            dw_q    <= '0;
        end else begin
            wr_q <= 1'b0;
            aw_q <= '0;
            dw_q <= '0;
            unique case (state)
                WAIT_MEM: begin
                    if (wb.flush) begin
                        state <= IDLE;
                    end else if (wb.mem_rvalid) begin
                        state <= WRITE;
                        aw_q  <= ld_aw;
                        dw_q  <= load_data(ld_byte, wb.mem_rdata);
                        wr_q  <= ld_rw && (ld_aw != XZR_ADDR);
                    end else if (expire) begin
                        state <= IDLE;
                    end
                end
                IDLE, WRITE: begin
                    if (wb.flush || !wb.valid_in) begin
                        state <= IDLE;
                    end else if (wb.load_in) begin
                        state   <= WAIT_MEM;
                        ld_aw   <= wb.Aw_in;
                        ld_byte <= wb.byte_in;
                        ld_rw   <= wb.RegWrite_in;
                    end else begin
                        state <= WRITE;
                        aw_q  <= wb.Aw_in;
                        dw_q  <= wb.MOVsel_in ? wb.MOVout_in : wb.ALUout_in;
                        wr_q  <= wb.RegWrite_in && (wb.Aw_in != XZR_ADDR);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: transaction-level model checked every cycle plus literal spot checks.
// Define WB_TIMEOUT_EN to exercise the timeout build (TIMEOUT_CYCLES=4).
module tb_wb_stage;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned T = 4;
`else
    localparam int unsigned T = 16;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    wb_stage_if bus();

    wb_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb      (bus)
    );

    always #5 clk = ~clk;

    // Model: an optional outstanding load and an optional write visible this cycle.
    logic        m_loading, m_ld_byte, m_ld_rw;
    logic [4:0]  m_ld_aw;
    int          m_wait;
    logic        m_wr, m_wr_rw;
    logic [4:0]  m_wr_aw;
    logic [63:0] m_wr_dw;
    logic        m_to;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_loading <= 1'b0; m_ld_byte <= 1'b0; m_ld_rw <= 1'b0; m_ld_aw <= '0;
            m_wait <= 0; m_wr <= 1'b0; m_wr_rw <= 1'b0; m_wr_aw <= '0; m_wr_dw <= '0;
            m_to <= 1'b0;
        end else if (bus.flush) begin
            m_loading <= 1'b0;
            m_wr      <= 1'b0;
        end else if (m_loading) begin
            m_wr <= 1'b0;
            if (bus.mem_rvalid) begin
                m_loading <= 1'b0;
                m_wr      <= 1'b1;
                m_wr_aw   <= m_ld_aw;
                m_wr_rw   <= m_ld_rw;
                m_wr_dw   <= m_ld_byte ? (bus.mem_rdata & 64'hFF) : bus.mem_rdata;
            end else begin
                m_wait <= m_wait + 1;
`ifdef WB_TIMEOUT_EN
                if (m_wait + 1 == int'(T)) begin
                    m_to      <= 1'b1;
                    m_loading <= 1'b0;
                end
`endif
            end
        end else if (bus.valid_in && bus.load_in) begin
            m_loading <= 1'b1;
            m_wait    <= 0;
            m_ld_aw   <= bus.Aw_in;
            m_ld_byte <= bus.byte_in;
            m_ld_rw   <= bus.RegWrite_in;
            m_wr      <= 1'b0;
        end else if (bus.valid_in) begin
            m_wr    <= 1'b1;
            m_wr_aw <= bus.Aw_in;
            m_wr_rw <= bus.RegWrite_in;
            m_wr_dw <= bus.MOVsel_in ? bus.MOVout_in : bus.ALUout_in;
        end else begin
            m_wr <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model RegWrite", 64'(bus.RegWrite), 64'(m_wr && m_wr_rw && m_wr_aw != 5'd31));
        chk("model AwWB", 64'(bus.AwWB), m_wr ? 64'(m_wr_aw) : 64'd0);
        chk("model Dw", bus.Dw, m_wr ? m_wr_dw : 64'd0);
        chk("model stall", 64'(bus.stall), 64'(m_loading));
        chk("model timeout_err", 64'(bus.timeout_err), 64'(m_to));
    end

    task automatic idle();
        bus.valid_in = 1'b0; bus.RegWrite_in = 1'b0; bus.load_in = 1'b0; bus.byte_in = 1'b0;
        bus.MOVsel_in = 1'b0; bus.Aw_in = '0; bus.ALUout_in = '0; bus.MOVout_in = '0;
        bus.mem_rdata = '0; bus.mem_rvalid = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic instr(input logic rw, input logic ld, input logic by, input logic mov,
                         input logic [4:0] aw, input logic [63:0] alu, input logic [63:0] movv);
        bus.valid_in = 1'b1; bus.RegWrite_in = rw; bus.load_in = ld; bus.byte_in = by;
        bus.MOVsel_in = mov; bus.Aw_in = aw; bus.ALUout_in = alu; bus.MOVout_in = movv;
    endtask

    task automatic mem(input logic v, input logic [63:0] d);
        bus.mem_rvalid = v;
        bus.mem_rdata  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        repeat (2) tick();
        chk("reset RegWrite", 64'(bus.RegWrite), 64'd0);
        chk("reset Dw", bus.Dw, 64'd0);
        chk("reset stall", 64'(bus.stall), 64'd0);
        reset_n = 1'b1;

        // ADD x3 = 5
        instr(1, 0, 0, 0, 5'd3, 64'h5, 64'h0);
        tick();
        chk("add RegWrite", 64'(bus.RegWrite), 64'd1);
        chk("add AwWB", 64'(bus.AwWB), 64'd3);
        chk("add Dw", bus.Dw, 64'h5);
        idle();
        tick();
        chk("add RegWrite drop", 64'(bus.RegWrite), 64'd0);

        // LDURB x7, data after three stall cycles
        instr(1, 1, 1, 0, 5'd7, 64'h0, 64'h0);
        tick();
        chk("ldurb stall c1", 64'(bus.stall), 64'd1);
        idle();
        tick();
        chk("ldurb stall c2", 64'(bus.stall), 64'd1);
        tick();
        chk("ldurb stall c3", 64'(bus.stall), 64'd1);
        mem(1, 64'hFFEE);
        tick();
        chk("ldurb stall end", 64'(bus.stall), 64'd0);
        chk("ldurb RegWrite", 64'(bus.RegWrite), 64'd1);
        chk("ldurb AwWB", 64'(bus.AwWB), 64'd7);
        chk("ldurb Dw", bus.Dw, 64'hEE);
        mem(0, 64'h0);
        tick();
        chk("ldurb RegWrite drop", 64'(bus.RegWrite), 64'd0);

        // LDUR x9 with an ADD held through the stall, then accepted straight out of WRITE
        instr(1, 1, 0, 0, 5'd9, 64'h0, 64'h0);
        tick();
        instr(1, 0, 0, 0, 5'd10, 64'h42, 64'h0);
        mem(1, 64'h1122334455667788);
        tick();
        chk("ldur Dw", bus.Dw, 64'h1122334455667788);
        chk("ldur AwWB", 64'(bus.AwWB), 64'd9);
        mem(0, 64'h0);
        tick();
        chk("b2b after load AwWB", 64'(bus.AwWB), 64'd10);
        chk("b2b after load Dw", bus.Dw, 64'h42);
        idle();
        tick();

        // MOVZ to XZR never writes; MOV to x4 takes MOV path
        instr(1, 0, 0, 1, 5'd31, 64'h99, 64'h10);
        tick();
        chk("movz xzr RegWrite", 64'(bus.RegWrite), 64'd0);
        instr(1, 0, 0, 1, 5'd4, 64'h99, 64'h10);
        tick();
        chk("mov RegWrite", 64'(bus.RegWrite), 64'd1);
        chk("mov Dw", bus.Dw, 64'h10);
        instr(0, 0, 0, 0, 5'd6, 64'h123, 64'h0);
        tick();
        chk("no-regwrite RegWrite", 64'(bus.RegWrite), 64'd0);
        idle();
        tick();

        // flush beats mem_rvalid in WAIT_MEM
        instr(1, 1, 0, 0, 5'd5, 64'h0, 64'h0);
        tick();
        idle();
        bus.flush = 1'b1;
        mem(1, 64'hAB);
        tick();
        chk("flush stall", 64'(bus.stall), 64'd0);
        chk("flush RegWrite", 64'(bus.RegWrite), 64'd0);
        idle();
        tick();
        chk("flush no late write", 64'(bus.RegWrite), 64'd0);

        // flush beats valid_in in IDLE
        instr(1, 0, 0, 0, 5'd8, 64'h77, 64'h0);
        bus.flush = 1'b1;
        tick();
        chk("flush blocks accept", 64'(bus.RegWrite), 64'd0);

        // back-to-back ALU ops
        bus.flush = 1'b0;
        instr(1, 0, 0, 0, 5'd1, 64'hA, 64'h0);
        tick();
        chk("b2b first RegWrite", 64'(bus.RegWrite), 64'd1);
        instr(1, 0, 0, 0, 5'd2, 64'hB, 64'h0);
        tick();
        chk("b2b second RegWrite", 64'(bus.RegWrite), 64'd1);
        chk("b2b second Dw", bus.Dw, 64'hB);
        idle();
        tick();
        chk("b2b drop", 64'(bus.RegWrite), 64'd0);

        // load with no data return
        instr(1, 1, 0, 0, 5'd6, 64'h0, 64'h0);
        tick();
        idle();
`ifdef WB_TIMEOUT_EN
        repeat (3) tick();
        chk("timeout still waiting", 64'(bus.stall), 64'd1);
        tick();
        chk("timeout stall", 64'(bus.stall), 64'd0);
        chk("timeout err", 64'(bus.timeout_err), 64'd1);
        chk("timeout no write", 64'(bus.RegWrite), 64'd0);
        mem(1, 64'h5A5A);
        tick();
        chk("late rvalid ignored", 64'(bus.RegWrite), 64'd0);
        mem(0, 64'h0);
        instr(1, 0, 0, 0, 5'd3, 64'h1, 64'h0);
        tick();
        chk("post-timeout write", 64'(bus.RegWrite), 64'd1);
        chk("timeout sticky", 64'(bus.timeout_err), 64'd1);
        idle();
        tick();
`else
        repeat (20) tick();
        chk("wait forever stall", 64'(bus.stall), 64'd1);
        chk("no timeout", 64'(bus.timeout_err), 64'd0);
        mem(1, 64'h5A5A);
        tick();
        chk("late load Dw", bus.Dw, 64'h5A5A);
        mem(0, 64'h0);
        tick();
`endif

        // async reset mid-WAIT_MEM
        instr(1, 1, 0, 0, 5'd8, 64'h0, 64'h0);
        tick();
        idle();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst stall", 64'(bus.stall), 64'd0);
        chk("async rst RegWrite", 64'(bus.RegWrite), 64'd0);
        chk("async rst AwWB", 64'(bus.AwWB), 64'd0);
        chk("async rst Dw", bus.Dw, 64'd0);
        chk("async rst timeout", 64'(bus.timeout_err), 64'd0);
        tick();
        reset_n = 1'b1;
        instr(1, 0, 0, 0, 5'd2, 64'h77, 64'h0);
        tick();
        chk("first edge after reset RegWrite", 64'(bus.RegWrite), 64'd1);
        chk("first edge after reset Dw", bus.Dw, 64'h77);
        idle();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, load-wait cycles before timeout error (range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid_in  input  1  instruction present from MEM stage.
REQ-005 SHALL have port RegWrite_in  input  1  instruction writes a register.
REQ-006 SHALL have port load_in  input  1  instruction is a load (LDUR/LDURB).
REQ-007 SHALL have port byte_in  input  1  load is byte-wide (LDURB).
REQ-008 SHALL have port MOVsel_in  input  1  result comes from MOV path.
REQ-009 SHALL have port Aw_in  input  5  destination register.
REQ-010 SHALL have ports ALUout_in, MOVout_in  input  64 each  EX results.
REQ-011 SHALL have ports mem_rdata  input  64 and mem_rvalid  input  1  load data return.
REQ-012 SHALL have port flush  input  1  discard held instruction.
REQ-013 SHALL have outputs RegWrite 1, AwWB 5, Dw 64  register-file write port.
REQ-014 SHALL have outputs stall 1 (hold upstream) and timeout_err 1 (sticky).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_MEM, WRITE.
REQ-016 SHALL accept an instruction on an edge where valid_in=1 and stall=0.
REQ-017 SHALL, for accepted non-load, latch Aw_in and result (MOVout_in if MOVsel_in else ALUout_in) and enter WRITE; write visible one cycle after acceptance.
REQ-018 SHALL, for accepted load, latch Aw_in, byte_in and enter WAIT_MEM.
REQ-019 SHALL drive stall=1 exactly while state==WAIT_MEM (combinational from state).
REQ-020 SHALL, in WAIT_MEM on edge with mem_rvalid=1, latch data (byte_in: {56'b0, mem_rdata[7:0]}; else full 64 bits) and enter WRITE.
REQ-021 SHALL assert RegWrite for exactly one cycle in WRITE, qualified by latched RegWrite_in and AwWB!=31; Dw/AwWB hold latched values in WRITE, zero otherwise.
REQ-022 SHALL, from WRITE, accept a new instruction on the same edge (back-to-back writes, no bubble); else return to IDLE.
REQ-023 SHALL ignore mem_rvalid in IDLE and WRITE.
REQ-024 SHALL, on flush=1, go to IDLE next edge with no write; flush overrides mem_rvalid and valid_in on the same edge.
REQ-025 SHALL count WAIT_MEM cycles, saturating at 8 bits; counter clears on entering WAIT_MEM.

Reset
REQ-026 SHALL, on reset_n=0, immediately force IDLE, RegWrite=0, AwWB=0, Dw=0, stall=0, timeout_err=0, counter=0, including mid-WAIT_MEM.
REQ-027 SHALL leave reset synchronously to clk; first acceptance possible on first edge after reset_n rises.

Configuration
REQ-028 SHALL, with macro WB_TIMEOUT_EN defined, set timeout_err when WAIT_MEM count reaches TIMEOUT_CYCLES, then abandon the load (IDLE, no write); timeout_err stays set until reset.
REQ-029 SHALL, without WB_TIMEOUT_EN, wait indefinitely in WAIT_MEM and tie timeout_err to 0.

Structure
REQ-030 SHALL take state enum wb_state_t and constant XZR_ADDR=5'd31 from shared package ee469_pkg.
REQ-031 SHALL place the wait counter and timeout compare in sub-module wb_timeout, instantiated only under WB_TIMEOUT_EN.

Verification
REQ-032 SHALL check: ADD accepted, Aw_in=3, ALUout_in=64'h5 -> next cycle RegWrite=1, AwWB=3, Dw=5, then RegWrite=0.
REQ-033 SHALL check: LDURB Aw_in=7, mem_rvalid after 3 cycles, mem_rdata=64'hFFEE -> stall=1 for 3 cycles, then RegWrite=1, Dw=64'hEE.
REQ-034 SHALL check: MOVZ with Aw_in=31, MOVout_in=64'h10 -> RegWrite stays 0.
REQ-035 SHALL check: flush and mem_rvalid together in WAIT_MEM -> IDLE, no write, stall=0 next cycle.
REQ-036 SHALL check: WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no mem_rvalid -> timeout_err=1 after 4 wait cycles, no write, sticky until reset.
REQ-037 SHALL check: reset_n low mid-WAIT_MEM -> all outputs 0 without clock edge; two consecutive ALU ops -> RegWrite high two consecutive cycles.
